// File: rtl/tlc_safety_monitor.sv
// Traffic-light safety monitor.
// Watches the highway/country light codes and the pedestrian signal once per
// enabled clock. It flags illegal codes, conflicting greens, bad sequencing,
// short yellows and highway starvation. The first fault is captured in a
// sticky flag/code pair. All fault events are counted, and completed
// country phases are counted as well.
module tlc_safety_monitor #(
    parameter int unsigned MIN_YELLOW = 4,
    parameter int unsigned MAX_RED    = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       clr_fault,
    input  logic [1:0] highway,
    input  logic [1:0] country,
    input  logic       pedestrian_light,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] fault_count,
    output logic [7:0] phase_count
);

    localparam logic [1:0] CODE_RED = 2'b00;
    localparam logic [1:0] CODE_YEL = 2'b01;
    localparam logic [1:0] CODE_GRN = 2'b10;
    localparam logic [1:0] CODE_ILL = 2'b11;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_ILLEGAL = 3'd1;
    localparam logic [2:0] FC_CONFL   = 3'd2;
    localparam logic [2:0] FC_PED     = 3'd3;
    localparam logic [2:0] FC_BADTR   = 3'd4;
    localparam logic [2:0] FC_SHORTY  = 3'd5;
    localparam logic [2:0] FC_STARVE  = 3'd6;

    localparam logic [3:0] MIN_YELLOW_L = 4'(MIN_YELLOW);
    localparam logic [7:0] MAX_RED_L    = 8'(MAX_RED);
    // The red dwell counter stops one past MAX_RED, so the starvation
    // compare can only match once per red interval.
    localparam logic [7:0] RED_SAT_L    = 8'(MAX_RED + 1);

    // The only legal code changes are G->Y, Y->R and R->G.
    // Holding the same code is also legal.
    function automatic logic step_is_legal(input logic [1:0] prev_code,
                                           input logic [1:0] cur_code);
        logic ok;
        ok = 1'b0;
        if (prev_code == cur_code) begin
            ok = 1'b1;
        end else begin
            case ({prev_code, cur_code})
                {CODE_GRN, CODE_YEL}: ok = 1'b1;
                {CODE_YEL, CODE_RED}: ok = 1'b1;
                {CODE_RED, CODE_GRN}: ok = 1'b1;
                default:              ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // An illegal code on either side makes the transition meaningless.
    // Such a sample is left entirely to the illegal-code check.
    function automatic logic bad_step(input logic [1:0] prev_code,
                                      input logic [1:0] cur_code);
        logic checked;
        checked = (prev_code != CODE_ILL) && (cur_code != CODE_ILL);
        return checked && !step_is_legal(prev_code, cur_code);
    endfunction

    // Y->R with fewer yellow samples than required.
    function automatic logic short_yellow(input logic [1:0] prev_code,
                                          input logic [1:0] cur_code,
                                          input logic [3:0] dwell);
        return (prev_code == CODE_YEL) && (cur_code == CODE_RED) &&
               (dwell < MIN_YELLOW_L);
    endfunction

    // The yellow dwell counter counts consecutive yellow samples.
    // It saturates at 15.
    function automatic logic [3:0] yel_dwell_next(input logic [1:0] code,
                                                  input logic [3:0] dwell);
        logic [3:0] nxt;
        if (code != CODE_YEL) begin
            nxt = 4'd0;
        end else if (dwell == 4'hF) begin
            nxt = dwell;
        end else begin
            nxt = dwell + 4'd1;
        end
        return nxt;
    endfunction

    // When several checks hit in the same sample, the lowest-numbered one is reported.
    function automatic logic [2:0] lowest_hit(input logic [5:0] hits);
        logic [2:0] code;
        if (hits[0]) begin
            code = FC_ILLEGAL;
        end else if (hits[1]) begin
            code = FC_CONFL;
        end else if (hits[2]) begin
            code = FC_PED;
        end else if (hits[3]) begin
            code = FC_BADTR;
        end else if (hits[4]) begin
            code = FC_SHORTY;
        end else if (hits[5]) begin
            code = FC_STARVE;
        end else begin
            code = FC_NONE;
        end
        return code;
    endfunction

    logic [1:0] hw_prev_r;
    logic [1:0] cr_prev_r;
    logic [3:0] hw_yel_dwell_r;
    logic [3:0] cr_yel_dwell_r;
    logic [7:0] hw_red_dwell_r;
    logic       fault_r;
    logic [2:0] fault_code_r;
    logic [7:0] fault_count_r;
    logic [7:0] phase_count_r;

    logic [5:0] hit_s;
    logic       event_s;
    logic [2:0] event_code_s;
    logic       fault_next_s;
    logic [2:0] fault_code_next_s;
    logic [7:0] fault_count_next_s;
    logic [7:0] phase_count_next_s;
    logic [3:0] hw_yel_dwell_next_s;
    logic [3:0] cr_yel_dwell_next_s;
    logic [7:0] hw_red_dwell_next_s;

    // Per-sample safety checks; every check is silent while disabled
    always_comb begin
        hit_s = 6'b000000;
        if (en) begin
            hit_s[0] = (highway == CODE_ILL) || (country == CODE_ILL);
            hit_s[1] = (highway != CODE_RED) && (country != CODE_RED);
            hit_s[2] = pedestrian_light && (highway != CODE_RED);
            hit_s[3] = bad_step(hw_prev_r, highway) || bad_step(cr_prev_r, country);
            hit_s[4] = short_yellow(hw_prev_r, highway, hw_yel_dwell_r) ||
                       short_yellow(cr_prev_r, country, cr_yel_dwell_r);
            hit_s[5] = (highway == CODE_RED) && (hw_red_dwell_r == MAX_RED_L);
        end else begin
            hit_s = 6'b000000;
        end
    end

    // Next-state for the sticky fault, counters and dwell trackers
    always_comb begin
        event_s             = |hit_s;
        event_code_s        = lowest_hit(hit_s);
        fault_next_s        = fault_r;
        fault_code_next_s   = fault_code_r;
        fault_count_next_s  = fault_count_r;
        phase_count_next_s  = phase_count_r;
        hw_yel_dwell_next_s = 4'd0;
        cr_yel_dwell_next_s = 4'd0;
        hw_red_dwell_next_s = 8'd0;

        // A new event overrides a simultaneous clear and captures its own code.
        if (event_s && (!fault_r || clr_fault)) begin
            fault_next_s      = 1'b1;
            fault_code_next_s = event_code_s;
        end else if (event_s) begin
            fault_next_s      = fault_r;
            fault_code_next_s = fault_code_r;
        end else if (clr_fault) begin
            fault_next_s      = 1'b0;
            fault_code_next_s = FC_NONE;
        end else begin
            fault_next_s      = fault_r;
            fault_code_next_s = fault_code_r;
        end

        if (event_s && (fault_count_r != 8'hFF)) begin
            fault_count_next_s = fault_count_r + 8'd1;
        end else begin
            fault_count_next_s = fault_count_r;
        end

        if (en && (cr_prev_r == CODE_YEL) && (country == CODE_RED)) begin
            phase_count_next_s = phase_count_r + 8'd1;
        end else begin
            phase_count_next_s = phase_count_r;
        end

        if (en) begin
            hw_yel_dwell_next_s = yel_dwell_next(highway, hw_yel_dwell_r);
            cr_yel_dwell_next_s = yel_dwell_next(country, cr_yel_dwell_r);
            if (highway != CODE_RED) begin
                hw_red_dwell_next_s = 8'd0;
            end else if (hw_red_dwell_r == RED_SAT_L) begin
                hw_red_dwell_next_s = hw_red_dwell_r;
            end else begin
                hw_red_dwell_next_s = hw_red_dwell_r + 8'd1;
            end
        end else begin
            hw_yel_dwell_next_s = 4'd0;
            cr_yel_dwell_next_s = 4'd0;
            hw_red_dwell_next_s = 8'd0;
        end
    end

    // State register. The previous-code registers track the inputs even while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            hw_prev_r      <= CODE_GRN;
            cr_prev_r      <= CODE_RED;
            hw_yel_dwell_r <= 4'd0;
            cr_yel_dwell_r <= 4'd0;
            hw_red_dwell_r <= 8'd0;
            fault_r        <= 1'b0;
            fault_code_r   <= FC_NONE;
            fault_count_r  <= 8'd0;
            phase_count_r  <= 8'd0;
        end else begin
            hw_prev_r      <= highway;
            cr_prev_r      <= country;
            hw_yel_dwell_r <= hw_yel_dwell_next_s;
            cr_yel_dwell_r <= cr_yel_dwell_next_s;
            hw_red_dwell_r <= hw_red_dwell_next_s;
            fault_r        <= fault_next_s;
            fault_code_r   <= fault_code_next_s;
            fault_count_r  <= fault_count_next_s;
            phase_count_r  <= phase_count_next_s;
        end
    end

    assign fault       = fault_r;
    assign fault_code  = fault_code_r;
    assign fault_count = fault_count_r;
    assign phase_count = phase_count_r;

endmodule

// File: tb/tb_tlc_safety_monitor.sv
// Bench for tlc_safety_monitor: directed scenarios with fixed expectations plus
// randomized traffic checked against a run-length based reference model.
module tb_tlc_safety_monitor;

    localparam int MIN_YELLOW = 4;
    localparam int MAX_RED    = 32;

    logic       clk;
    logic       rst;
    logic       en;
    logic       clr_fault;
    logic [1:0] highway;
    logic [1:0] country;
    logic       pedestrian_light;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] fault_count;
    logic [7:0] phase_count;

    int total;
    int bad;

    // Reference model state: light history as run lengths of the current colour.
    bit m_fault;
    int m_code;
    int m_fcnt;
    int m_phase;
    int m_hw_prev;
    int m_cr_prev;
    int m_hw_yrun;
    int m_cr_yrun;
    int m_hw_rrun;

    tlc_safety_monitor #(.MIN_YELLOW(MIN_YELLOW), .MAX_RED(MAX_RED)) dut (
        .clk(clk), .rst(rst), .en(en), .clr_fault(clr_fault),
        .highway(highway), .country(country), .pedestrian_light(pedestrian_light),
        .fault(fault), .fault_code(fault_code), .fault_count(fault_count),
        .phase_count(phase_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Colours: 0 red, 1 yellow, 2 green, 3 illegal. A light cycles green->yellow->red->green.
    function automatic bit model_bad_step(input int p, input int c);
        if (p == 3 || c == 3 || p == c) return 1'b0;
        if ((p == 2 && c == 1) || (p == 1 && c == 0) || (p == 0 && c == 2)) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_update(input bit r, input bit e, input bit c,
                                input int h, input int cr, input bit p);
        int ev;
        ev = 0;
        if (r) begin
            m_fault = 1'b0; m_code = 0; m_fcnt = 0; m_phase = 0;
            m_hw_yrun = 0; m_cr_yrun = 0; m_hw_rrun = 0;
            m_hw_prev = 2; m_cr_prev = 0;
        end else begin
            if (e) begin
                if (h == 3 || cr == 3) ev = 1;
                else if (h != 0 && cr != 0) ev = 2;
                else if (p && h != 0) ev = 3;
                else if (model_bad_step(m_hw_prev, h) || model_bad_step(m_cr_prev, cr)) ev = 4;
                else if ((m_hw_prev == 1 && h == 0 && m_hw_yrun < MIN_YELLOW) ||
                         (m_cr_prev == 1 && cr == 0 && m_cr_yrun < MIN_YELLOW)) ev = 5;
                else if (h == 0 && m_hw_rrun == MAX_RED) ev = 6;
                if (m_cr_prev == 1 && cr == 0) m_phase = (m_phase + 1) % 256;
                m_hw_yrun = (h == 1) ? m_hw_yrun + 1 : 0;
                m_cr_yrun = (cr == 1) ? m_cr_yrun + 1 : 0;
                m_hw_rrun = (h == 0) ? m_hw_rrun + 1 : 0;
            end else begin
                m_hw_yrun = 0; m_cr_yrun = 0; m_hw_rrun = 0;
            end
            if (ev != 0) begin
                if (m_fcnt < 255) m_fcnt = m_fcnt + 1;
                if (!m_fault || c) begin
                    m_fault = 1'b1;
                    m_code  = ev;
                end
            end else if (c) begin
                m_fault = 1'b0;
                m_code  = 0;
            end
            m_hw_prev = h;
            m_cr_prev = cr;
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit c,
                        input int h, input int cr, input bit p);
        rst = r; en = e; clr_fault = c;
        highway = 2'(h); country = 2'(cr); pedestrian_light = p;
        @(posedge clk);
        #1;
        model_update(r, e, c, h, cr, p);
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        total++;
        if ({fault, fault_code, fault_count, phase_count} !== 20'd0) begin
            bad++;
            $display("FAIL reset: got f=%0d c=%0d n=%0d p=%0d want all 0",
                     fault, fault_code, fault_count, phase_count);
        end
    endtask

    task automatic test_legal_cycle();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b1, 1'b0, 2, 0, 1'b0);
        for (int i = 0; i < 4; i++)  tick(1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 8; i++)  tick(1'b0, 1'b1, 1'b0, 0, 2, 1'b0);
        for (int i = 0; i < 4; i++)  tick(1'b0, 1'b1, 1'b0, 0, 1, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2, 0, 1'b0);
        total++;
        if (fault !== 1'b0 || phase_count !== 8'd1 || fault_count !== 8'd0) begin
            bad++;
            $display("FAIL legal_cycle: got f=%0d p=%0d n=%0d want f=0 p=1 n=0",
                     fault, phase_count, fault_count);
        end
    endtask

    task automatic test_short_yellow();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        total++;
        if (fault !== 1'b0) begin
            bad++;
            $display("FAIL short_yellow_pre: got f=%0d want 0", fault);
        end
        tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd5 || fault_count !== 8'd1) begin
            bad++;
            $display("FAIL short_yellow: got f=%0d c=%0d n=%0d want f=1 c=5 n=1",
                     fault, fault_code, fault_count);
        end
    endtask

    task automatic test_conflict();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2, 2, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 2, 2, 1'b0);
        total++;
        if (fault_code !== 3'd2 || fault_count !== 8'd2) begin
            bad++;
            $display("FAIL conflict: got c=%0d n=%0d want c=2 n=2", fault_code, fault_count);
        end
        tick(1'b0, 1'b1, 1'b0, 3, 2, 1'b0);
        total++;
        if (fault_code !== 3'd2 || fault_count !== 8'd3) begin
            bad++;
            $display("FAIL conflict_sticky: got c=%0d n=%0d want c=2 n=3", fault_code, fault_count);
        end
    endtask

    task automatic test_ped_and_clear();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
        total++;
        if (fault_code !== 3'd3) begin
            bad++;
            $display("FAIL ped_conflict: got c=%0d want 3", fault_code);
        end
        tick(1'b0, 1'b1, 1'b1, 1, 0, 1'b0);
        total++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || fault_count !== 8'd1) begin
            bad++;
            $display("FAIL clear: got f=%0d c=%0d n=%0d want f=0 c=0 n=1",
                     fault, fault_code, fault_count);
        end
        // A clear coinciding with a new event captures the new code.
        tick(1'b0, 1'b1, 1'b0, 1, 0, 1'b1);
        tick(1'b0, 1'b1, 1'b1, 3, 0, 1'b0);
        total++;
        if (fault !== 1'b1 || fault_code !== 3'd1 || fault_count !== 8'd3) begin
            bad++;
            $display("FAIL clear_vs_event: got f=%0d c=%0d n=%0d want f=1 c=1 n=3",
                     fault, fault_code, fault_count);
        end
    endtask

    task automatic test_starve();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        for (int i = 0; i < MIN_YELLOW; i++) tick(1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        for (int i = 1; i <= 40; i++) begin
            tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
            if (i == MAX_RED) begin
                total++;
                if (fault !== 1'b0) begin
                    bad++;
                    $display("FAIL starve_early: got f=%0d want 0 at red sample %0d", fault, i);
                end
            end
            if (i == MAX_RED + 1) begin
                total++;
                if (fault !== 1'b1 || fault_code !== 3'd6) begin
                    bad++;
                    $display("FAIL starve_fire: got f=%0d c=%0d want f=1 c=6", fault, fault_code);
                end
            end
        end
        total++;
        if (fault_count !== 8'd1) begin
            bad++;
            $display("FAIL starve_once: got n=%0d want 1", fault_count);
        end
    endtask

    task automatic test_bad_transition();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        total++;
        if (fault_code !== 3'd4) begin
            bad++;
            $display("FAIL bad_transition: got c=%0d want 4", fault_code);
        end
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        total++;
        if (fault !== 1'b0 || fault_count !== 8'd0) begin
            bad++;
            $display("FAIL disabled_no_check: got f=%0d n=%0d want 0 0", fault, fault_count);
        end
        // Reset in the middle of a yellow interval forgets the earlier yellows.
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        tick(1'b1, 1'b1, 1'b0, 1, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        total++;
        if (fault_code !== 3'd5) begin
            bad++;
            $display("FAIL reset_mid_yellow: got c=%0d want 5", fault_code);
        end
    endtask

    task automatic test_enable_resume();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b1, 1'b0, 1, 0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1, 0, 1'b0);
        tick(1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
        total++;
        if (fault_code !== 3'd5 || fault_count !== 8'd1) begin
            bad++;
            $display("FAIL enable_resume: got c=%0d n=%0d want c=5 n=1", fault_code, fault_count);
        end
    endtask

    task automatic test_saturation();
        tick(1'b1, 1'b1, 1'b0, 2, 0, 1'b0);
        for (int i = 0; i < 260; i++) tick(1'b0, 1'b1, 1'b0, 2, 2, 1'b0);
        total++;
        if (fault_count !== 8'd255 || fault_code !== 3'd2) begin
            bad++;
            $display("FAIL count_saturate: got n=%0d c=%0d want n=255 c=2", fault_count, fault_code);
        end
    endtask

    function automatic int rand_light(input int cur);
        int r;
        r = int'($urandom_range(0, 99));
        if (r < 60) return cur;
        if (r < 92) begin
            if (cur == 2) return 1;
            if (cur == 1) return 0;
            if (cur == 0) return 2;
            return int'($urandom_range(0, 2));
        end
        return int'($urandom_range(0, 3));
    endfunction

    task automatic test_random();
        int h;
        int cr;
        bit r;
        bit e;
        bit c;
        bit p;
        h = 2;
        cr = 0;
        tick(1'b1, 1'b1, 1'b0, h, cr, 1'b0);
        for (int i = 0; i < 3000; i++) begin
            h  = rand_light(h);
            cr = rand_light(cr);
            r  = ($urandom_range(0, 199) == 0);
            e  = ($urandom_range(0, 19) != 0);
            c  = ($urandom_range(0, 19) == 0);
            p  = ($urandom_range(0, 9) == 0);
            tick(r, e, c, h, cr, p);
            total++;
            if (fault !== m_fault || fault_code !== 3'(m_code) ||
                fault_count !== 8'(m_fcnt) || phase_count !== 8'(m_phase)) begin
                bad++;
                $display("FAIL random[%0d]: got f=%0d c=%0d n=%0d p=%0d want f=%0d c=%0d n=%0d p=%0d",
                         i, fault, fault_code, fault_count, phase_count,
                         m_fault, m_code, m_fcnt, m_phase);
            end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1; en = 1'b0; clr_fault = 1'b0;
        highway = 2'b10; country = 2'b00; pedestrian_light = 1'b0;
        test_reset();
        test_legal_cycle();
        test_short_yellow();
        test_conflict();
        test_ped_and_clear();
        test_starve();
        test_bad_transition();
        test_enable_resume();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tlc_safety_monitor.md
TLC_SAFETY_MONITOR -- requirements
Module: tlc_safety_monitor

Interface
REQ-001 Parameters SHALL be: MIN_YELLOW, default 4, minimum consecutive yellow samples per road before red (1..15).
REQ-002 Parameters SHALL be: MAX_RED, default 32, maximum consecutive highway-red samples before starvation fault (1..254).
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- en  in  1  monitor enable.
- clr_fault  in  1  clears sticky fault.
- highway  in  2  highway light code: 00 red, 01 yellow, 10 green, 11 illegal.
- country  in  2  country light code, same encoding.
- pedestrian_light  in  1  1 walk, 0 stop.
- fault  out  1  sticky fault flag.
- fault_code  out  3  first captured fault, 0 = none.
- fault_count  out  8  saturating count of fault events.
- phase_count  out  8  wrapping count of completed country phases.

Function
REQ-004 Inputs SHALL be sampled every rising clk edge while en=1; all outputs SHALL be registered, with 1-cycle latency from offending sample to output.
REQ-005 Per-sample check 1 (ILLEGAL_CODE=1): highway or country = 11.
REQ-006 Per-sample check 2 (CONFLICT=2): highway and country both non-red.
REQ-007 Per-sample check 3 (PED_CONFLICT=3): pedestrian_light=1 while highway non-red.
REQ-008 Per-sample check 4 (BAD_TRANSITION=4): a road changes code other than G->Y, Y->R, R->G.
REQ-009 Per-sample check 5 (SHORT_YELLOW=5): Y->R on a road with yellow dwell < MIN_YELLOW.
REQ-010 Per-sample check 6 (STARVE=6): highway red with red dwell = MAX_RED.
REQ-011 Unchanged codes SHALL be legal transitions; checks 4 and 5 SHALL be skipped when either previous or current code is 11.
REQ-012 Per-road yellow dwell counter (4-bit): cleared when code not yellow, else incremented saturating at 15; value compared at Y->R equals yellow samples seen.
REQ-013 Highway red dwell counter (8-bit): cleared when highway not red, else incremented saturating at MAX_RED+1, so STARVE fires once per red interval.
REQ-014 Multiple hits in one sample SHALL count as one fault event; reported code SHALL be the lowest-numbered hit.
REQ-015 On a fault event with fault=0: fault<=1, fault_code<=event code; with fault=1: fault_code unchanged.
REQ-016 Every fault event SHALL increment fault_count, saturating at 255.
REQ-017 clr_fault=1 SHALL clear fault and fault_code next cycle; a fault event in the same cycle SHALL win and load its code.
REQ-018 clr_fault SHALL NOT clear fault_count or phase_count.
REQ-019 phase_count SHALL increment (mod 256) on every country Y->R sample, regardless of fault status.
REQ-020 Previous-code registers SHALL load current inputs every cycle (en=1 or 0).
REQ-021 With en=0: no checks, no counts, dwell counters cleared; fault, fault_code, fault_count, phase_count hold.
REQ-022 On first sample after en rises, transition checks SHALL compare against the inputs captured while disabled.

Reset
REQ-023 rst SHALL force: fault=0, fault_code=0, fault_count=0, phase_count=0, dwell counters 0, previous highway=10 (green), previous country=00 (red).
REQ-024 rst SHALL take priority over en and clr_fault; reset mid-interval SHALL discard all dwell history.

Verification
REQ-025 Legal cycle HW G x10, Y x4, R; CR G x8, Y x4, R; HW G -> fault=0, phase_count=1, fault_count=0.
REQ-026 HW Y x3 then R -> next cycle fault=1, fault_code=5, fault_count=1.
REQ-027 HW=10, CR=10 for 2 samples -> fault_code=2, fault_count=2; then HW=11 -> fault_code stays 2, fault_count=3.
REQ-028 HW=01 with pedestrian_light=1 -> fault_code=3; assert clr_fault with clean inputs -> fault=0, fault_code=0, fault_count kept.
REQ-029 Highway red for 40 samples, MAX_RED=32 -> exactly one STARVE event, fault_code=6 on sample 33, fault_count=1.
REQ-030 HW G->R directly, en=1 -> fault_code=4; same with en=0 -> no fault; rst mid-yellow then HW=01->00 -> fault_code=5.
